// File: rtl/memory.sv
// Single-port synchronous RAM slave with a valid/ready request handshake.
// Storage is a register array so the whole array can be cleared by reset.
module memory #(
  parameter  int WIDTH      = 8,
  parameter  int DEPTH      = 32,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_rd,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  input  logic                  valid,
  output logic                  ready
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No wait states: every request is accepted unless reset is active.
  assign ready = valid & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else if (valid) begin
      if (wr_rd) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: tb/tb_memory.sv
// Directed bench for memory: stimulus pushes expected read data into a queue,
// a monitor pops and compares whenever a read is accepted.
module tb_memory;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  logic            clk;
  logic            rst;
  logic [AW-1:0]   addr;
  logic            wr_rd;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic            valid;
  logic            ready;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model [DEPTH];
  logic [WIDTH-1:0] exp_q [$];

  memory #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .wr_rd (wr_rd),
    .wdata (wdata),
    .rdata (rdata),
    .valid (valid),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // One request per call; inputs change on the falling edge, transfer on the next rising edge.
  task automatic req(input logic w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    valid = 1'b1;
    wr_rd = w;
    addr  = a;
    wdata = d;
    #1;
    chk("ready_on_request", {31'd0, ready}, 32'd1);
    if (w) model[a] = d;
    else   exp_q.push_back(model[a]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid = 1'b0;
      wr_rd = 1'b0;
      addr  = 'x;
      wdata = 'x;
    end
  endtask

  // Monitor: a read accepted at a rising edge must show its data by the falling edge.
  initial begin
    logic acc;
    logic [WIDTH-1:0] e;
    forever begin
      @(posedge clk);
      acc = valid && ready && !wr_rd;
      @(negedge clk);
      if (acc) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_read", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", {24'd0, rdata}, {24'd0, e});
        end
      end
    end
  end

  initial begin
    rst   = 1'b1;
    valid = 1'b1;
    wr_rd = 1'b0;
    addr  = '0;
    wdata = '0;
    clear_model();

    // Reset held for two cycles with a request asserted: ready must stay low.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata", {24'd0, rdata}, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    valid = 1'b0;
    rst   = 1'b0;
    req(1'b0, 5'd0, '0);
    req(1'b0, 5'd17, '0);
    req(1'b0, 5'd31, '0);
    idle(1);

    req(1'b1, 5'd0, 8'h65);
    req(1'b0, 5'd0, '0);
    idle(2);

    // Full sweep: odd values 51, 55, ... 175.
    for (int a = 0; a < DEPTH; a++) begin
      req(1'b1, AW'(a), WIDTH'(51 + 4 * a));
      req(1'b0, AW'(a), '0);
    end
    idle(2);

    // Even locations only after a fresh reset; odd words must still read 0.
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a += 2) begin
      req(1'b1, AW'(a), WIDTH'(8'hA0 + a));
      req(1'b0, AW'(a), '0);
    end
    req(1'b0, 5'd1, '0);
    idle(1);
    chk("odd_word_cleared", {24'd0, rdata}, 32'd0);

    // Hold: rdata keeps its value while idle.
    req(1'b1, 5'd5, 8'hC7);
    req(1'b0, 5'd5, '0);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      #1;
      chk("hold_rdata", {24'd0, rdata}, 32'hC7);
      chk("hold_ready", {31'd0, ready}, 32'd0);
    end

    // Reset while a read of addr 3 is pending, before its accepting edge.
    req(1'b1, 5'd3, 8'h99);
    @(negedge clk);
    valid = 1'b1;
    wr_rd = 1'b0;
    addr  = 5'd3;
    #1;
    chk("pending_ready", {31'd0, ready}, 32'd1);
    rst = 1'b1;
    clear_model();
    #1;
    chk("midreset_rdata", {24'd0, rdata}, 32'd0);
    chk("midreset_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    valid = 1'b0;
    rst   = 1'b0;
    req(1'b0, 5'd3, '0);
    idle(3);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
